// File: rtl/aes_core_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : aes_core_arbiter
// Purpose  : Round-robin scheduler sharing one AES_top encrypt/decrypt core
//            between NREQ requesters. It accepts one {key, text, direction}
//            job at a time, pulses the core reset for one cycle, and enables
//            the core until completedFlag rises or a watchdog expires. The
//            result is returned tagged with the owning requester ID.
// Ports    : wb_clk_i / wb_rst_n_i      clock, async active-low reset
//            req_*                      per-requester job inputs + accept
//            rsp_*                      result channel (valid/ready)
//            core_*                     connection to the AES_top instance
//            busy_o                     high whenever a job is in flight
// Revision : 1.0  initial release
// ============================================================================
module aes_core_arbiter #(
    parameter  int NREQ    = 4,
    parameter  int TIMEOUT = 1024,
    localparam int IW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_n_i,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [NREQ*128-1:0]  req_key_i,
    input  logic [NREQ*128-1:0]  req_text_i,
    input  logic [NREQ-1:0]      req_enc_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [IW-1:0]        rsp_id_o,
    output logic [127:0]         rsp_data_o,
    output logic                 rsp_err_o,
    output logic [127:0]         core_key_o,
    output logic [127:0]         core_data_o,
    output logic                 core_ed_o,
    output logic                 core_en_o,
    output logic                 core_rst_o,
    input  logic                 core_done_i,
    input  logic [127:0]         core_data_i,
    output logic                 busy_o
);

    localparam logic [15:0]   C_WD_LAST   = 16'(TIMEOUT - 1);
    localparam logic [IW-1:0] C_LAST_INIT = IW'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [IW-1:0]   r_last_grant;
    logic [15:0]     r_wdog;

    logic            w_found;
    logic [IW-1:0]   w_winner;
    logic [IW-1:0]   w_cand;
    logic [NREQ-1:0] w_ready;

    // Round-robin pick: scan starting just after the previous winner so the
    // last-served requester has the lowest priority this time around.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_last_grant;
        w_cand   = r_last_grant;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = IW'((int'(r_last_grant) + k) % NREQ);
            if (!w_found && req_valid_i[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if (r_state == ST_IDLE && w_found) begin
            w_ready[w_winner] = 1'b1;
        end
    end

    // Next-state logic. core_done_i is looked at only in RUN so a flag left
    // high from the previous job cannot complete the new one.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_found) w_next = ST_CLEAR;
            ST_CLEAR: w_next = ST_RUN;
            ST_RUN:   if (core_done_i || r_wdog == C_WD_LAST) w_next = ST_RESP;
            ST_RESP:  if (rsp_ready_i) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state      <= ST_IDLE;
            r_last_grant <= C_LAST_INIT;
            r_wdog       <= 16'd0;
            rsp_id_o     <= '0;
            rsp_data_o   <= 128'd0;
            rsp_err_o    <= 1'b0;
            core_key_o   <= 128'd0;
            core_data_o  <= 128'd0;
            core_ed_o    <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        core_key_o   <= req_key_i[int'(w_winner)*128 +: 128];
                        core_data_o  <= req_text_i[int'(w_winner)*128 +: 128];
                        core_ed_o    <= req_enc_i[w_winner];
                        rsp_id_o     <= w_winner;
                        r_last_grant <= w_winner;
                    end
                end
                ST_CLEAR: begin
                    r_wdog <= 16'd0;
                end
                ST_RUN: begin
                    // Done takes priority over a simultaneous watchdog expiry.
                    if (core_done_i) begin
                        rsp_data_o <= core_data_i;
                        rsp_err_o  <= 1'b0;
                    end else if (r_wdog == C_WD_LAST) begin
                        rsp_data_o <= 128'd0;
                        rsp_err_o  <= 1'b1;
                    end else begin
                        r_wdog <= r_wdog + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready_o = w_ready;
    assign rsp_valid_o = (r_state == ST_RESP);
    assign core_en_o   = (r_state == ST_RUN);
    // Core is held in reset while our own reset is asserted, and pulsed for
    // one cycle at the start of every job to flush stale internal state.
    assign core_rst_o  = !wb_rst_n_i || (r_state == ST_CLEAR);
    assign busy_o      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_aes_core_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_core_arbiter
// Purpose  : Self-checking bench for aes_core_arbiter. A job-level model
//            predicts grants, the one-cycle core reset, RUN window and the
//            response; a simple core model answers after a set latency.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_aes_core_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;
    localparam int IW      = $clog2(NREQ);

    localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*128-1:0] req_key = '0;
    logic [NREQ*128-1:0] req_text = '0;
    logic [NREQ-1:0]     req_enc = '0;
    logic                rsp_valid;
    logic                rsp_ready = 1'b0;
    logic [IW-1:0]       rsp_id;
    logic [127:0]        rsp_data;
    logic                rsp_err;
    logic [127:0]        core_key;
    logic [127:0]        core_text;
    logic                core_ed;
    logic                core_en;
    logic                core_rst;
    logic                core_done = 1'b0;
    logic [127:0]        core_din = '0;
    logic                busy;

    always #5 clk = ~clk;

    aes_core_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i    (clk),
        .wb_rst_n_i  (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_key_i   (req_key),
        .req_text_i  (req_text),
        .req_enc_i   (req_enc),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_id_o    (rsp_id),
        .rsp_data_o  (rsp_data),
        .rsp_err_o   (rsp_err),
        .core_key_o  (core_key),
        .core_data_o (core_text),
        .core_ed_o   (core_ed),
        .core_en_o   (core_en),
        .core_rst_o  (core_rst),
        .core_done_i (core_done),
        .core_data_i (core_din),
        .busy_o      (busy)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stand-in for AES_top: the known FIPS-197 vector, otherwise a mixing
    // function that is distinct per key/text/direction.
    function automatic logic [127:0] core_fn(logic [127:0] k, logic [127:0] t, logic e);
        if (k == K0 && t == P0 && e) return C0;
        return (k ^ {t[63:0], t[127:64]}) + {127'd0, e} + 128'h5a5a;
    endfunction

    function automatic int pick(logic [NREQ-1:0] v, int last);
        for (int k = 1; k <= NREQ; k++)
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    // ------------------------------------------------------------------
    // Core model and requester behaviour, advanced once per clock.
    // ------------------------------------------------------------------
    int run_cnt    = 0;
    int lat        = 3;     // done in the lat-th enabled cycle; 0 = never
    bit force_done = 1'b0;
    bit auto_drop  = 1'b1;  // requesters drop valid after their accept

    task automatic tick();
        logic [NREQ-1:0] rdy;
        @(negedge clk);
        rdy = req_ready;
        @(posedge clk);
        #1;
        if (auto_drop) req_valid = req_valid & ~rdy;
        run_cnt   = core_en ? run_cnt + 1 : 0;
        core_done = force_done || (lat != 0 && core_en && run_cnt == lat);
        core_din  = core_fn(core_key, core_text, core_ed);
    endtask

    // ------------------------------------------------------------------
    // Job-level reference model, compared every cycle at the falling edge.
    // ------------------------------------------------------------------
    int           cyc = 0;
    bit           m_busy = 0, m_resp = 0, m_enc = 0, m_err = 0;
    int           m_acc = 0, m_last = NREQ - 1, m_id = 0;
    logic [127:0] m_key = '0, m_text = '0, m_data = '0;

    int           acc_log[$];
    int           rsp_id_log[$];
    logic [127:0] rsp_data_log[$];
    int           rsp_err_log[$];
    int           rsp_lat_log[$];   // cycles from accept cycle to first valid

    always @(negedge clk) begin
        logic [NREQ-1:0] er;
        bit e_en, e_rst, e_val;
        int w;
        cyc++;
        if (!rst_n) begin
            m_busy = 0; m_resp = 0; m_last = NREQ - 1;
            m_key = '0; m_text = '0; m_enc = 0;
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_id",    rsp_id, 0);
            chk("rst_rsp_data",  rsp_data, 0);
            chk("rst_rsp_err",   rsp_err, 0);
            chk("rst_core_key",  core_key, 0);
            chk("rst_core_data", core_text, 0);
            chk("rst_core_ed",   core_ed, 0);
            chk("rst_core_en",   core_en, 0);
            chk("rst_core_rst",  core_rst, 1);
            chk("rst_busy",      busy, 0);
        end else begin
            er = '0; e_en = 0; e_rst = 0; e_val = 0; w = -1;
            if (!m_busy) begin
                w = pick(req_valid, m_last);
                if (w >= 0) er[w] = 1'b1;
            end else if (cyc == m_acc + 1) e_rst = 1;
            else if (!m_resp) e_en = 1;
            else e_val = 1;

            chk("req_ready", req_ready, er);
            chk("core_en",   core_en, e_en);
            chk("core_rst",  core_rst, e_rst);
            chk("rsp_valid", rsp_valid, e_val);
            chk("busy",      busy, m_busy);
            chk("core_key",  core_key, m_key);
            chk("core_data", core_text, m_text);
            chk("core_ed",   core_ed, m_enc);
            if (e_val) begin
                chk("rsp_id",   rsp_id, m_id);
                chk("rsp_data", rsp_data, m_data);
                chk("rsp_err",  rsp_err, m_err);
            end

            if (!m_busy) begin
                if (w >= 0) begin
                    m_busy = 1; m_acc = cyc; m_last = w; m_id = w;
                    m_key  = req_key[w*128 +: 128];
                    m_text = req_text[w*128 +: 128];
                    m_enc  = req_enc[w];
                    acc_log.push_back(w);
                end
            end else if (cyc == m_acc + 1) begin
                // reset pulse cycle: done flag is irrelevant here
            end else if (!m_resp) begin
                if (core_done) begin
                    m_resp = 1; m_data = core_din; m_err = 0;
                end else if (cyc - (m_acc + 2) == TIMEOUT - 1) begin
                    m_resp = 1; m_data = '0; m_err = 1;
                end
                if (m_resp) begin
                    rsp_id_log.push_back(m_id);
                    rsp_data_log.push_back(m_data);
                    rsp_err_log.push_back(m_err);
                    rsp_lat_log.push_back(cyc + 1 - m_acc);
                end
            end else if (rsp_ready) begin
                m_busy = 0; m_resp = 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic wait_idle(input int n_rsp, input int budget);
        int t = 0;
        while ((rsp_err_log.size() < n_rsp || busy || req_valid != 0) && t < budget) begin
            tick();
            t++;
        end
        if (t >= budget) begin
            n_vec++; n_err++;
            $display("FAIL wait_idle: still busy after %0d cycles, responses %0d required %0d",
                     t, rsp_err_log.size(), n_rsp);
        end
    endtask

    task automatic chk_rsp(input string name, input int idx, input int id,
                           input logic [127:0] data, input int err, input int latency);
        if (idx >= rsp_err_log.size()) begin
            n_vec++; n_err++;
            $display("FAIL %s: response %0d missing, got %0d responses", name, idx, rsp_err_log.size());
        end else begin
            chk({name, "_id"},   rsp_id_log[idx], id);
            chk({name, "_data"}, rsp_data_log[idx], data);
            chk({name, "_err"},  rsp_err_log[idx], err);
            if (latency > 0) chk({name, "_lat"}, rsp_lat_log[idx], latency);
        end
    endtask

    task automatic set_job(input int n, input logic [127:0] k, input logic [127:0] t, input logic e);
        req_key[n*128 +: 128]  = k;
        req_text[n*128 +: 128] = t;
        req_enc[n]             = e;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int a0, r0, t;
        int order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

        repeat (3) tick();
        @(negedge clk); #2 rst_n = 1'b1;
        tick();

        // Fairness: all requesters hold valid for eight jobs.
        a0 = acc_log.size(); r0 = rsp_err_log.size();
        for (int n = 0; n < NREQ; n++) set_job(n, rnd128(), rnd128(), n[0]);
        auto_drop = 0; lat = 2; rsp_ready = 1'b1; req_valid = '1;
        t = 0;
        while (acc_log.size() < a0 + 8 && t < 400) begin tick(); t++; end
        req_valid = '0; auto_drop = 1;
        wait_idle(r0 + 8, 100);
        for (int i = 0; i < 8; i++) begin
            if (a0 + i < acc_log.size()) chk("fair_order", acc_log[a0 + i], order[i]);
            else chk("fair_order_missing", acc_log.size(), a0 + 8);
        end

        // Single job with the FIPS-197 vector; done in 4th RUN cycle (k=3).
        r0 = rsp_err_log.size();
        set_job(0, K0, P0, 1'b1); lat = 4; req_valid = 4'b0001;
        wait_idle(r0 + 1, 100);
        chk_rsp("single", r0, 0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0, 6);

        // Watchdog: no done; valid appears TIMEOUT+2 cycles after the accept cycle.
        r0 = rsp_err_log.size();
        set_job(1, rnd128(), rnd128(), 1'b0); lat = 0; req_valid = 4'b0010;
        wait_idle(r0 + 1, 100);
        chk_rsp("watchdog", r0, 1, 128'd0, 1, TIMEOUT + 2);
        set_job(2, 128'h1111, 128'h2222, 1'b1); lat = 3; req_valid = 4'b0100;
        wait_idle(r0 + 2, 100);
        chk_rsp("after_wd", r0 + 1, 2, core_fn(128'h1111, 128'h2222, 1'b1), 0, 5);

        // Backpressure followed by a stale done flag into the next CLEAR.
        r0 = rsp_err_log.size();
        set_job(0, 128'hA0, 128'hB0, 1'b1);
        set_job(3, 128'hC3, 128'hD3, 1'b0);
        rsp_ready = 1'b0; lat = 2; req_valid = 4'b0001;
        t = 0;
        while (!rsp_valid && t < 50) begin tick(); t++; end
        chk("bp_rsp_seen", rsp_valid, 1);
        req_valid[3] = 1'b1;
        a0 = acc_log.size();
        repeat (10) tick();
        chk("bp_no_accept", acc_log.size(), a0);
        force_done = 1; rsp_ready = 1'b1; lat = 3;
        t = 0;
        while (!core_rst && t < 20) begin tick(); t++; end
        chk("stale_clear_seen", core_rst, 1);
        force_done = 0;
        wait_idle(r0 + 2, 100);
        chk_rsp("bp_first", r0, 0, core_fn(128'hA0, 128'hB0, 1'b1), 0, 0);
        chk_rsp("stale", r0 + 1, 3, core_fn(128'hC3, 128'hD3, 1'b0), 0, 5);

        // Done in the same cycle the watchdog would expire: done wins.
        r0 = rsp_err_log.size();
        set_job(1, 128'h77, 128'h88, 1'b1); lat = TIMEOUT; req_valid = 4'b0010;
        wait_idle(r0 + 1, 100);
        chk_rsp("collide", r0, 1, core_fn(128'h77, 128'h88, 1'b1), 0, TIMEOUT + 2);

        // Asynchronous reset in the middle of RUN.
        r0 = rsp_err_log.size();
        set_job(2, rnd128(), rnd128(), 1'b1); lat = 0; req_valid = 4'b0100;
        t = 0;
        while (!core_en && t < 20) begin tick(); t++; end
        repeat (3) tick();
        req_valid = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("async_core_rst",  core_rst, 1);
        chk("async_core_en",   core_en, 0);
        chk("async_rsp_valid", rsp_valid, 0);
        chk("async_busy",      busy, 0);
        chk("async_core_key",  core_key, 0);
        repeat (2) tick();
        @(negedge clk); #2 rst_n = 1'b1;
        tick();
        chk("async_no_rsp", rsp_err_log.size(), r0);
        a0 = acc_log.size();
        lat = 2; req_valid = '1;
        wait_idle(r0 + NREQ, 200);
        if (a0 < acc_log.size()) chk("post_reset_first", acc_log[a0], 0);
        else chk("post_reset_missing", acc_log.size(), a0 + 1);

        // Randomized traffic.
        auto_drop = 0;
        for (int i = 0; i < 1500; i++) begin
            req_valid = NREQ'($urandom);
            for (int n = 0; n < NREQ; n++)
                if ($urandom_range(3) == 0) set_job(n, rnd128(), rnd128(), 1'($urandom));
            rsp_ready = ($urandom_range(9) < 7);
            if (!busy) lat = $urandom_range(TIMEOUT + 4);
            force_done = ($urandom_range(15) == 0) && !core_en;
            tick();
        end
        force_done = 0; req_valid = '0; rsp_ready = 1'b1; auto_drop = 1;
        wait_idle(0, 200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
